// File: rtl/sq_out_normalizer.sv
// sq_out_normalizer
//   Converts the redundant coefficient bus of the squaring pipeline into a
//   non-redundant MOD_LEN-bit integer and an overflow flag. One sequential
//   carry-propagation pass per squared polynomial: capture, accumulate, hold.
//   Build option: define SQ_NORM_TWO_LANES_EN to fold two lanes per cycle.
//   The results are bit-identical to the default one-lane build.

`ifndef MOD_LEN_DEF
`define MOD_LEN_DEF 1024
`endif

module sq_out_normalizer #(
    parameter int MOD_LEN               = `MOD_LEN_DEF,
    parameter int WORD_LEN              = 16,
    parameter int REDUNDANT_ELEMENTS    = 0,
    parameter int NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
    parameter int NUM_ELEMENTS          = REDUNDANT_ELEMENTS + NONREDUNDANT_ELEMENTS,
    parameter int SQ_OUT_BITS           = NUM_ELEMENTS * WORD_LEN * 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sq_out_valid,
    input  logic [SQ_OUT_BITS-1:0] sq_out,
    output logic                   in_ready,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [MOD_LEN-1:0]     result,
    output logic                   overflow
);

    localparam int LANE_W = 2 * WORD_LEN;
    localparam int IDX_W  = $clog2(NUM_ELEMENTS + 1);

`ifdef SQ_NORM_TWO_LANES_EN
    localparam int LANES_PER_STEP = 2;

    // Pairs of lanes are consumed per cycle, so the lane count must be even.
    generate
        if (NUM_ELEMENTS % 2 != 0) begin : g_odd_lanes
            $error("sq_out_normalizer: NUM_ELEMENTS must be even when SQ_NORM_TWO_LANES_EN is defined");
        end
    endgenerate
`else
    localparam int LANES_PER_STEP = 1;
`endif

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_ELEMENTS - LANES_PER_STEP);
    localparam logic [IDX_W-1:0] IDX_STEP   = IDX_W'(LANES_PER_STEP);
    localparam logic [IDX_W-1:0] NONRED_IDX = IDX_W'(NONREDUNDANT_ELEMENTS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]             r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [WORD_LEN:0]      r_carry;
    logic [MOD_LEN-1:0]     r_result;
    logic                   r_overflow;
    logic [SQ_OUT_BITS-1:0] r_lanes;

    logic                   w_accept;
    logic                   w_last;
    logic [LANE_W:0]        w_sum0;
    logic [WORD_LEN:0]      w_carry0;
    logic [WORD_LEN:0]      w_step_carry;
    logic                   w_ovf_step;
`ifdef SQ_NORM_TWO_LANES_EN
    logic [LANE_W:0]        w_sum1;
    logic [WORD_LEN:0]      w_carry1;
`endif

    // Reset gates in_ready directly, so no bus is taken while reset is held.
    assign in_ready     = (r_state == S_IDLE) && !reset;
    assign w_accept     = in_ready && sq_out_valid;
    assign w_last       = (r_idx == LAST_IDX);
    assign result_valid = (r_state == S_DONE);
    assign result       = r_result;
    assign overflow     = r_overflow;

    // Carry chain across the lane(s) sitting at the bottom of the lane register.
    always_comb begin
        w_sum0   = {1'b0, r_lanes[LANE_W-1:0]} + {{(LANE_W-WORD_LEN){1'b0}}, r_carry};
        w_carry0 = w_sum0[LANE_W:WORD_LEN];
`ifdef SQ_NORM_TWO_LANES_EN
        w_sum1       = {1'b0, r_lanes[2*LANE_W-1:LANE_W]} + {{(LANE_W-WORD_LEN){1'b0}}, w_carry0};
        w_carry1     = w_sum1[LANE_W:WORD_LEN];
        w_step_carry = w_carry1;
`else
        w_step_carry = w_carry0;
`endif
    end

    // Overflow contributions of this step: redundant words and the final carry.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_ovf_step = 1'b0;
        if (r_idx >= NONRED_IDX)
            w_ovf_step = w_ovf_step | (w_sum0[WORD_LEN-1:0] != '0);
`ifdef SQ_NORM_TWO_LANES_EN
        if (r_idx + IDX_W'(1) >= NONRED_IDX)
            w_ovf_step = w_ovf_step | (w_sum1[WORD_LEN-1:0] != '0);
`endif
        if (w_last)
            w_ovf_step = w_ovf_step | (w_step_carry != '0);
    end

    // Lane capture at accept, then shift the next lane(s) down each ACCUM cycle.
    // NOTE: this is pure datapath storage that is only read under ACCUM, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_lanes <= sq_out;
        else if (r_state == S_ACCUM)
            r_lanes <= r_lanes >> (LANES_PER_STEP * LANE_W);
    end

    // Control FSM and result accumulation; result words shift in from the top.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every update reads pre-edge values.
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_carry    <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_ACCUM;
                        r_idx      <= '0;
                        r_carry    <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    r_carry    <= w_step_carry;
                    r_idx      <= r_idx + IDX_STEP;
                    r_overflow <= r_overflow | w_ovf_step;
`ifdef SQ_NORM_TWO_LANES_EN
                    if (r_idx + IDX_W'(1) < NONRED_IDX)
                        r_result <= {w_sum1[WORD_LEN-1:0], w_sum0[WORD_LEN-1:0],
                                     r_result[MOD_LEN-1:2*WORD_LEN]};
                    else if (r_idx < NONRED_IDX)
                        r_result <= {w_sum0[WORD_LEN-1:0], r_result[MOD_LEN-1:WORD_LEN]};
`else
                    if (r_idx < NONRED_IDX)
                        r_result <= {w_sum0[WORD_LEN-1:0], r_result[MOD_LEN-1:WORD_LEN]};
`endif
                    if (w_last)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    if (result_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sq_out_normalizer.sv
// tb_sq_out_normalizer
//   Directed vectors with hand-computed results for the default build
//   (1024-bit result, 64 lanes of 32 bits). Checks latency, the result,
//   overflow, backpressure and a mid-pass reset.

`timescale 1ns/1ps

module tb_sq_out_normalizer;

    localparam int N   = 64;
    localparam int W   = 16;
    localparam int LW  = 2 * W;
    localparam int BUS = N * LW;
    localparam int ML  = N * W;
`ifdef SQ_NORM_TWO_LANES_EN
    localparam int LAT = N / 2;
    localparam int LPS = 2;
`else
    localparam int LAT = N;
    localparam int LPS = 1;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           sq_out_valid;
    logic [BUS-1:0] sq_out;
    logic           in_ready;
    logic           result_valid;
    logic           result_ready;
    logic [ML-1:0]  result;
    logic           overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [BUS-1:0] bus;
    logic [ML-1:0]  exp_res;

    sq_out_normalizer dut (
        .clk          (clk),
        .reset        (reset),
        .sq_out_valid (sq_out_valid),
        .sq_out       (sq_out),
        .in_ready     (in_ready),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic make_bus(input logic [31:0] first, input logic [31:0] rest,
                            input logic [31:0] last, output logic [BUS-1:0] b);
        for (int j = 0; j < N; j++) b[j*LW +: LW] = rest;
        b[0 +: LW]       = first;
        b[(N-1)*LW +: LW] = last;
    endtask

    task automatic scramble_bus();
        for (int j = 0; j < N; j++) sq_out[j*LW +: LW] = $urandom();
    endtask

    task automatic accept_bus(input string tag, input logic [BUS-1:0] b);
        int wait_cnt = 0;
        while (!in_ready && wait_cnt < 200) begin
            tick();
            wait_cnt++;
        end
        if (!in_ready) check({tag, "_in_ready_timeout"}, 512'(in_ready), 512'(1));
        sq_out       = b;
        sq_out_valid = 1'b1;
        tick();
        sq_out_valid = 1'b0;
        scramble_bus();
    endtask

    task automatic wait_done(input string tag);
        int cnt = 0;
        while (!result_valid && cnt < 200) begin
            tick();
            cnt++;
        end
        check({tag, "_latency"}, 512'(cnt), 512'(LAT));
    endtask

    task automatic check_out(input string tag, input logic [ML-1:0] exp, input logic exp_ovf);
        check({tag, "_result_lo"}, result[511:0], exp[511:0]);
        check({tag, "_result_hi"}, result[ML-1:512], exp[ML-1:512]);
        check({tag, "_overflow"}, 512'(overflow), 512'(exp_ovf));
    endtask

    task automatic release_result(input string tag);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check({tag, "_in_ready_after"}, 512'(in_ready), 512'(1));
        check({tag, "_valid_after"}, 512'(result_valid), 512'(0));
    endtask

    task automatic run(input string tag, input logic [BUS-1:0] b,
                       input logic [ML-1:0] exp, input logic exp_ovf);
        accept_bus(tag, b);
        wait_done(tag);
        check_out(tag, exp, exp_ovf);
        release_result(tag);
    endtask

    initial begin
        reset        = 1'b1;
        sq_out_valid = 1'b0;
        result_ready = 1'b0;
        sq_out       = '0;
        tick();
        tick();
        check("rst_in_ready", 512'(in_ready), 512'(0));
        check("rst_result_valid", 512'(result_valid), 512'(0));
        check_out("rst", '0, 1'b0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 512'(in_ready), 512'(1));

        // All-zero lanes.
        make_bus(32'h0, 32'h0, 32'h0, bus);
        run("zeros", bus, '0, 1'b0);

        // Every lane 0xFFFF: all-ones result, no carries.
        make_bus(32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, bus);
        run("all_ffff", bus, '1, 1'b0);

        // A single carry out of lane 0 into word 1.
        make_bus(32'h0001_0000, 32'h0, 32'h0, bus);
        exp_res = '0;
        exp_res[16] = 1'b1;
        run("carry1", bus, exp_res, 1'b0);

        // Carry ripples through every word and out the top.
        make_bus(32'h0001_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, bus);
        exp_res = '0;
        exp_res[15:0] = 16'hFFFF;
        run("ripple", bus, exp_res, 1'b1);

        // Top lane alone overflows; result stays zero.
        make_bus(32'h0, 32'h0, 32'h0001_0000, bus);
        run("top_ovf", bus, '0, 1'b1);

        // Max lanes: 17-bit carries; word1 = FFFE, rest FFFF, final carry 0x10000.
        make_bus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bus);
        exp_res = '1;
        exp_res[16] = 1'b0;
        accept_bus("bp", bus);
        wait_done("bp");
        for (int i = 0; i < 10; i++) begin
            sq_out_valid = (i % 2 == 0);
            scramble_bus();
            tick();
            check("bp_in_ready", 512'(in_ready), 512'(0));
            check("bp_valid", 512'(result_valid), 512'(1));
        end
        sq_out_valid = 1'b0;
        check_out("bp_hold", exp_res, 1'b1);
        release_result("bp");

        // Next bus after backpressure is accepted normally.
        make_bus(32'h0001_0000, 32'h0, 32'h0, bus);
        exp_res = '0;
        exp_res[16] = 1'b1;
        run("after_bp", bus, exp_res, 1'b0);

        // Reset in the middle of ACCUM at idx 20.
        make_bus(32'h0001_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, bus);
        accept_bus("mid_rst", bus);
        for (int i = 0; i < 20 / LPS; i++) tick();
        reset = 1'b1;
        tick();
        check("mid_rst_valid", 512'(result_valid), 512'(0));
        check("mid_rst_in_ready", 512'(in_ready), 512'(0));
        check_out("mid_rst", '0, 1'b0);
        reset = 1'b0;
        #1;
        check("mid_rst_idle", 512'(in_ready), 512'(1));

        // Fresh accept after the abort completes correctly.
        make_bus(32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, bus);
        run("fresh", bus, '1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
